// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register. Hazards become bubbles, flush kills the captured instruction, freeze holds the stage.
// Optional macro FWD_SRC_EN registers the source indices for the forwarding unit.
module id_exe_stage_reg #(
    parameter int unsigned DW    = 32,
    parameter int unsigned RW    = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             hazard,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             id_b,
    input  logic             id_s,
    input  logic [3:0]       id_exe_cmd,
    input  logic [DW-1:0]    id_pc,
    input  logic [DW-1:0]    id_val_rn,
    input  logic [DW-1:0]    id_val_rm,
    input  logic             id_imm,
    input  logic [11:0]      id_shift_op,
    input  logic [23:0]      id_simm24,
    input  logic [RW-1:0]    id_dest,
    input  logic [3:0]       id_sr,
    input  logic [RW-1:0]    id_src1,
    input  logic [RW-1:0]    id_src2,
    output logic             exe_wb_en,
    output logic             exe_mem_r_en,
    output logic             exe_mem_w_en,
    output logic             exe_b,
    output logic             exe_s,
    output logic [3:0]       exe_exe_cmd,
    output logic [DW-1:0]    exe_pc,
    output logic [DW-1:0]    exe_val_rn,
    output logic [DW-1:0]    exe_val_rm,
    output logic             exe_imm,
    output logic [11:0]      exe_shift_op,
    output logic [23:0]      exe_simm24,
    output logic [RW-1:0]    exe_dest,
    output logic [3:0]       exe_sr,
    output logic [RW-1:0]    exe_src1,
    output logic [RW-1:0]    exe_src2,
    output logic             exe_valid,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic upd;
    logic squash;
    logic flush_inc;
    logic bubble_inc;

    // Edge action decode: freeze > flush > hazard > load
    always_comb begin
        upd        = 1'b0;
        squash     = 1'b0;
        flush_inc  = 1'b0;
        bubble_inc = 1'b0;
        if (!freeze) begin
            upd = 1'b1;
            if (flush) begin
                squash    = 1'b1;
                flush_inc = 1'b1;
            end else if (hazard) begin
                squash     = 1'b1;
                bubble_inc = 1'b1;
            end
        end
    end

    // Control fields: zeroed on bubble/flush so the squashed slot has no side effects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_wb_en    <= 1'b0;
            exe_mem_r_en <= 1'b0;
            exe_mem_w_en <= 1'b0;
            exe_b        <= 1'b0;
            exe_s        <= 1'b0;
            exe_exe_cmd  <= 4'd0;
            exe_valid    <= 1'b0;
        end else if (upd) begin
            if (squash) begin
                exe_wb_en    <= 1'b0;
                exe_mem_r_en <= 1'b0;
                exe_mem_w_en <= 1'b0;
                exe_b        <= 1'b0;
                exe_s        <= 1'b0;
                exe_exe_cmd  <= 4'd0;
                exe_valid    <= 1'b0;
            end else begin
                exe_wb_en    <= id_wb_en;
                exe_mem_r_en <= id_mem_r_en;
                exe_mem_w_en <= id_mem_w_en;
                exe_b        <= id_b;
                exe_s        <= id_s;
                exe_exe_cmd  <= id_exe_cmd;
                exe_valid    <= 1'b1;
            end
        end
    end

    // Data fields load on every non-frozen edge; meaningless while exe_valid is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_pc       <= '0;
            exe_val_rn   <= '0;
            exe_val_rm   <= '0;
            exe_imm      <= 1'b0;
            exe_shift_op <= 12'd0;
            exe_simm24   <= 24'd0;
            exe_dest     <= '0;
            exe_sr       <= 4'd0;
        end else if (upd) begin
            exe_pc       <= id_pc;
            exe_val_rn   <= id_val_rn;
            exe_val_rm   <= id_val_rm;
            exe_imm      <= id_imm;
            exe_shift_op <= id_shift_op;
            exe_simm24   <= id_simm24;
            exe_dest     <= id_dest;
            exe_sr       <= id_sr;
        end
    end

`ifdef FWD_SRC_EN
    // Source indices cleared on a squash so forwarding never matches a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_src1 <= '0;
            exe_src2 <= '0;
        end else if (upd) begin
            if (squash) begin
                exe_src1 <= '0;
                exe_src2 <= '0;
            end else begin
                exe_src1 <= id_src1;
                exe_src2 <= id_src2;
            end
        end
    end
`else
    logic unused_src;
    assign unused_src = ^{id_src1, id_src2};
    assign exe_src1   = '0;
    assign exe_src2   = '0;
`endif

    // Saturating perf counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (bubble_inc && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: stimulus pushes expected stage contents, a monitor pops and compares.
module tb_id_exe_stage_reg;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  cmd;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shift_op;
        logic [23:0] simm24;
        logic [3:0]  dest;
        logic [3:0]  sr;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } fields_t;

    typedef struct packed {
        fields_t    f;
        logic       valid;
        logic [3:0] bc;
        logic [3:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic freeze, flush, hazard;
    fields_t din;

    logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm, exe_valid;
    logic [3:0]  exe_exe_cmd, exe_dest, exe_sr, exe_src1, exe_src2;
    logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
    logic [11:0] exe_shift_op;
    logic [23:0] exe_simm24;
    logic [3:0]  bubble_cnt, flush_cnt;

    exp_t q[$];
    exp_t mdl;
    logic async_chk = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.DW(32), .RW(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .id_wb_en(din.wb_en), .id_mem_r_en(din.mem_r_en), .id_mem_w_en(din.mem_w_en),
        .id_b(din.b), .id_s(din.s), .id_exe_cmd(din.cmd), .id_pc(din.pc),
        .id_val_rn(din.rn), .id_val_rm(din.rm), .id_imm(din.imm), .id_shift_op(din.shift_op),
        .id_simm24(din.simm24), .id_dest(din.dest), .id_sr(din.sr),
        .id_src1(din.src1), .id_src2(din.src2),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
        .exe_b(exe_b), .exe_s(exe_s), .exe_exe_cmd(exe_exe_cmd), .exe_pc(exe_pc),
        .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm), .exe_imm(exe_imm),
        .exe_shift_op(exe_shift_op), .exe_simm24(exe_simm24), .exe_dest(exe_dest),
        .exe_sr(exe_sr), .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_valid(exe_valid),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    function automatic fields_t mk(input logic [4:0] ctl, input logic [3:0] cmd,
                                   input logic [31:0] pc, input logic [3:0] dest,
                                   input logic [3:0] src1);
        fields_t f;
        f.wb_en    = ctl[4];
        f.mem_r_en = ctl[3];
        f.mem_w_en = ctl[2];
        f.b        = ctl[1];
        f.s        = ctl[0];
        f.cmd      = cmd;
        f.pc       = pc;
        f.rn       = pc + 32'h0000_1000;
        f.rm       = ~pc;
        f.imm      = pc[2];
        f.shift_op = pc[11:0] ^ 12'hABC;
        f.simm24   = pc[23:0] ^ 24'h5A5A5A;
        f.dest     = dest;
        f.sr       = dest ^ 4'h9;
        f.src1     = src1;
        f.src2     = src1 + 4'd1;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT state against the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge async_chk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ctrl", 192'({exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_exe_cmd}),
                    192'({e.f.wb_en, e.f.mem_r_en, e.f.mem_w_en, e.f.b, e.f.s, e.f.cmd}));
                chk("data", 192'({exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_op,
                                  exe_simm24, exe_dest, exe_sr}),
                    192'({e.f.pc, e.f.rn, e.f.rm, e.f.imm, e.f.shift_op, e.f.simm24,
                          e.f.dest, e.f.sr}));
                chk("src", 192'({exe_src1, exe_src2}), 192'({e.f.src1, e.f.src2}));
                chk("valid", 192'(exe_valid), 192'(e.valid));
                chk("bubble_cnt", 192'(bubble_cnt), 192'(e.bc));
                chk("flush_cnt", 192'(flush_cnt), 192'(e.fc));
            end
        end
    end

    // Drive one edge worth of inputs and record the stage contents expected after it
    task automatic step(input logic frz, input logic fl, input logic hz, input fields_t d);
        freeze = frz;
        flush  = fl;
        hazard = hz;
        din    = d;
        if (!rst) begin
            mdl = '0;
        end else if (!frz) begin
            mdl.f = d;
            if (fl || hz) begin
                {mdl.f.wb_en, mdl.f.mem_r_en, mdl.f.mem_w_en, mdl.f.b, mdl.f.s} = 5'b0;
                mdl.f.cmd  = 4'd0;
                mdl.f.src1 = 4'd0;
                mdl.f.src2 = 4'd0;
                mdl.valid  = 1'b0;
                if (fl) begin
                    if (mdl.fc != 4'hF) mdl.fc = mdl.fc + 4'd1;
                end else begin
                    if (mdl.bc != 4'hF) mdl.bc = mdl.bc + 4'd1;
                end
            end else begin
                mdl.valid = 1'b1;
            end
`ifndef FWD_SRC_EN
            mdl.f.src1 = 4'd0;
            mdl.f.src2 = 4'd0;
`endif
        end
        q.push_back(mdl);
        @(negedge clk);
    endtask

    task automatic async_check();
        q.push_back(mdl);
        async_chk = 1'b1;
        #2;
        async_chk = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        hazard = 1'b0;
        din    = mk(5'b11111, 4'hF, 32'hFFFF_FFF0, 4'hF, 4'hF);
        mdl    = '0;
        repeat (2) @(negedge clk);
        #1;
        async_check();                                             // reset state, all zero
        @(negedge clk);
        rst = 1'b1;

        step(1'b0, 1'b0, 1'b0, mk(5'b10000, 4'b0010, 32'h0000_0100, 4'd5, 4'd1));  // normal load
        step(1'b0, 1'b0, 1'b1, mk(5'b10000, 4'h3, 32'h0000_0104, 4'd6, 4'd2));     // hazard 1
        step(1'b0, 1'b0, 1'b1, mk(5'b10000, 4'h3, 32'h0000_0108, 4'd6, 4'd2));     // hazard 2
        step(1'b0, 1'b1, 1'b1, mk(5'b11010, 4'h4, 32'h0000_010C, 4'd7, 4'd3));     // flush wins
        step(1'b0, 1'b0, 1'b0, mk(5'b01101, 4'h9, 32'h0000_0200, 4'd8, 4'd4));     // load
        step(1'b1, 1'b1, 1'b0, mk(5'b11111, 4'hA, 32'h0000_0010, 4'd9, 4'd5));     // freeze beats flush
        step(1'b1, 1'b0, 1'b1, mk(5'b11111, 4'hB, 32'h0000_0014, 4'd9, 4'd5));     // freeze beats hazard
        step(1'b0, 1'b0, 1'b0, mk(5'b00100, 4'hC, 32'hDEAD_BEEC, 4'd14, 4'd13));
        step(1'b0, 1'b0, 1'b0, mk(5'b10011, 4'h1, 32'h8000_0000, 4'd0, 4'd15));

        for (int i = 0; i < 20; i++) begin                                        // bubble saturation
            step(1'b0, 1'b0, 1'b1, mk(5'b11111, 4'h7, 32'h0000_1000 + 32'(i * 4), 4'd2, 4'd3));
        end
        for (int i = 0; i < 18; i++) begin                                        // flush saturation
            step(1'b0, 1'b1, 1'b0, mk(5'b10101, 4'h5, 32'h0000_2000 + 32'(i * 4), 4'd4, 4'd6));
        end
        step(1'b0, 1'b1, 1'b1, mk(5'b11111, 4'h6, 32'h0000_3000, 4'd1, 4'd1));     // both saturated
        step(1'b0, 1'b0, 1'b0, mk(5'b10000, 4'hE, 32'h0000_4000, 4'd11, 4'd12));   // exe_wb_en=1

        #2;
        rst = 1'b0;                                                                // mid-cycle reset
        mdl = '0;
        async_check();
        step(1'b0, 1'b0, 1'b0, mk(5'b11111, 4'h8, 32'h0000_5000, 4'd3, 4'd2));     // held in reset
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, mk(5'b10000, 4'h2, 32'h0000_6000, 4'd10, 4'd9));   // counting restarts
        step(1'b0, 1'b0, 1'b0, mk(5'b10001, 4'hD, 32'h0000_6004, 4'd12, 4'd8));

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
